tdm_demux_rx: RTL and testbench
===============================

# tdm_demux_rx

Receive-side time-division demultiplexer: takes one time-multiplexed word stream (one word per slot, slot 0 marked by a frame strobe) and steers each word to its own registered lane output with a one-cycle valid pulse. It is the far end of the team's 2:1 / N:1 multiplexer paths, sitting after a link or serializer and recovering the per-lane words. A framing state machine hunts for the frame strobe, tracks the slot position, and flags misalignment.

## Interface
- LANES, 2, number of slots per frame / output lanes (2..16)
- WIDTH, 8, bits per word
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in  in  WIDTH  incoming slot word
- in_valid  in  1  `in` carries a word this cycle
- frame  in  1  qualified by `in_valid`; current word is slot 0
- out  out  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]; registered
- out_valid  out  LANES  one-hot pulse; bit k high for one cycle when lane k is updated
- sel  out  clog2(LANES)  current expected slot index (debug/status)
- locked  out  1  framer in LOCKED state
- frame_err  out  1  one-cycle pulse on any framing violation

## Operation
- States: HUNT, LOCKED.
- HUNT: words without `frame` are discarded, no `out_valid`. On `in_valid && frame`: word goes to lane 0, `sel` <= 1 (wraps to 0 if LANES==1 is not allowed; LANES>=2), state -> LOCKED.
- LOCKED, `in_valid`, `frame`=0, `sel`!=0: word to lane `sel`; `sel` increments, wraps LANES-1 -> 0.
- LOCKED, `in_valid`, `frame`=1, `sel`==0: normal frame start; word to lane 0, `sel` <= 1.
- LOCKED, `in_valid`, `frame`=1, `sel`!=0 (early frame): `frame_err` pulse; word accepted as slot 0 (lane 0), `sel` <= 1; stay LOCKED.
- LOCKED, `in_valid`, `frame`=0, `sel`==0 (missing frame): `frame_err` pulse; word discarded; state -> HUNT; `sel` <= 0.
- `in_valid`=0: no state, `sel`, or lane change; `frame` ignored.
- Lanes not written hold their previous value; only the written lane's `out_valid` bit pulses.
- `sel` arithmetic: clog2(LANES) bits, explicit compare to LANES-1 for wrap (non-power-of-two LANES must wrap correctly).

## Timing
- Latency: word on `in` at edge N appears on `out` lane and `out_valid` after edge N (visible cycle N+1); exactly one cycle.
- `frame_err` asserted in the same cycle as the corresponding `out_valid` (or alone, for a discarded word).
- Back-to-back `in_valid` every cycle supported; no stall/backpressure.
- Reset (any time, including mid-frame): state HUNT, `sel`=0, `out`=0, `out_valid`=0, `locked`=0, `frame_err`=0; a word presented in the reset-release cycle is processed normally from HUNT.
- `locked` is a registered state decode: rises the cycle after the first accepted frame word, falls the cycle after a missing-frame error.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined: extra input `in_par` (1 bit, even parity over `in`, qualified by `in_valid`) and extra output `par_err` (1-cycle pulse, reset 0). Word with bad parity: `par_err` pulses, word discarded (no `out_valid`), but slot counting and framing advance exactly as if accepted.
- Not defined: no `in_par`/`par_err` ports; all words accepted per framing rules.

## Test plan
- LANES=2, WIDTH=8: reset, then frame+0xA5, 0x3C -> lane0=0xA5 with out_valid=01, lane1=0x3C with out_valid=10, locked=1, frame_err never high.
- HUNT discard: 0x11, 0x22 without frame, then frame+0x33 -> no out_valid for first two, lane0=0x33, locked rises next cycle.
- LANES=3: frame+1, 2, frame+4 (early) -> lane0=1, lane1=2, then frame_err pulse with lane0=4, sel=1.
- Missing frame, LANES=2: frame+0x10, 0x20, 0x30 (no frame) -> lanes 0x10/0x20, then frame_err, 0x30 dropped, locked falls.
- Gaps and reset: frame+0x01, idle 3 cycles, rst pulse mid-frame, then 0x02 -> lane0 cleared to 0, 0x02 discarded in HUNT, all outputs at reset values.
- With TDM_DEMUX_PARITY_EN: frame+0x07 with in_par=0 (bad) -> par_err pulse, no out_valid, next word 0x03 (good) lands in lane1.

Source files
------------

// File: rtl/tdm_demux_rx.sv
// Receive-side TDM demultiplexer: framing FSM steers each slot word to its own registered lane.
// Define TDM_DEMUX_PARITY_EN to add the in_par input and par_err output (even parity over in).
module tdm_demux_rx #(
  parameter  int LANES = 2,
  parameter  int WIDTH = 8,
  localparam int SW    = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in,
  input  logic                   in_valid,
  input  logic                   frame,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic                   in_par,
  output logic                   par_err,
`endif
  output logic [LANES*WIDTH-1:0] out,
  output logic [LANES-1:0]       out_valid,
  output logic [SW-1:0]          sel,
  output logic                   locked,
  output logic                   frame_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t        state_q;
  logic [SW-1:0] sel_q;
  logic          locked_q;
  logic          frame_err_q;

  logic          accept;
  logic          par_ok;
  logic          wr;
  logic [SW-1:0] slot;
  logic          sel_last;

  assign sel_last = (sel_q == SW'(LANES - 1));

  // Which lane (if any) the current word belongs to, before the parity check.
  always_comb begin
    accept = 1'b0;
    slot   = '0;
    if (in_valid) begin
      if (state_q == HUNT) begin
        accept = frame;
      end else if (frame) begin
        accept = 1'b1;
      end else if (sel_q != '0) begin
        accept = 1'b1;
        slot   = sel_q;
      end
    end
  end

  assign wr = accept && par_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      sel_q       <= '0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          HUNT: begin
            if (frame) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              sel_q    <= SW'(1);
            end
          end
          LOCKED: begin
            if (frame) begin
              frame_err_q <= (sel_q != '0);
              sel_q       <= SW'(1);
            end else if (sel_q == '0) begin
              // Expected a frame strobe and did not get one: drop lock and hunt again.
              frame_err_q <= 1'b1;
              state_q     <= HUNT;
              locked_q    <= 1'b0;
              sel_q       <= '0;
            end else begin
              sel_q <= sel_last ? '0 : sel_q + SW'(1);
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            sel_q    <= '0;
          end
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             hit;

    assign hit = wr && (slot == SW'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= hit;
        if (hit) data_q <= in;
      end
    end

    assign out[gi*WIDTH +: WIDTH] = data_q;
    assign out_valid[gi]          = valid_q;
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic par_err_q;

  assign par_ok = ~^{in, in_par};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= in_valid && !par_ok;
  end

  assign par_err = par_err_q;
`else
  assign par_ok = 1'b1;
`endif

  assign sel       = sel_q;
  assign locked    = locked_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Bench for tdm_demux_rx: LANES=2 and LANES=3 instances share one stimulus stream and
// are checked every cycle against a slot-position model of the framing rules.
module tb_tdm_demux_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        in_valid;
  logic        frame;

  logic [15:0] out2;
  logic [1:0]  ov2;
  logic        sel2;
  logic        lk2, fe2;
  logic [23:0] out3;
  logic [2:0]  ov3;
  logic [1:0]  sel3;
  logic        lk3, fe3;

`ifdef TDM_DEMUX_PARITY_EN
  logic in_par;
  logic pe2, pe3;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  always #5 clk = ~clk;

  tdm_demux_rx #(.LANES(2), .WIDTH(8)) u2 (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .frame(frame),
`ifdef TDM_DEMUX_PARITY_EN
    .in_par(in_par), .par_err(pe2),
`endif
    .out(out2), .out_valid(ov2), .sel(sel2), .locked(lk2), .frame_err(fe2)
  );

  tdm_demux_rx #(.LANES(3), .WIDTH(8)) u3 (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .frame(frame),
`ifdef TDM_DEMUX_PARITY_EN
    .in_par(in_par), .par_err(pe3),
`endif
    .out(out3), .out_valid(ov3), .sel(sel3), .locked(lk3), .frame_err(fe3)
  );

  // Model state, index 0 -> 2-lane instance, index 1 -> 3-lane instance.
  bit         m_locked [2];
  int         m_pos    [2];
  logic [7:0] m_lane   [2][3];
  int         m_valid  [2];
  bit         m_ferr   [2];
  bit         m_perr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_out(input int d);
    logic [63:0] v = '0;
    for (int k = 0; k < d + 2; k++) v |= 64'(m_lane[d][k]) << (8 * k);
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_locked[d] = 1'b0;
      m_pos[d]    = 0;
      m_valid[d]  = 0;
      m_ferr[d]   = 1'b0;
      for (int k = 0; k < 3; k++) m_lane[d][k] = '0;
    end
    m_perr = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit f, input logic [7:0] d, input bit bad);
    bit bad_eff;
`ifdef TDM_DEMUX_PARITY_EN
    bad_eff = bad;
`else
    bad_eff = 1'b0 & bad;
`endif
    for (int i = 0; i < 2; i++) begin
      int n = i + 2;
      int slot = -1;
      m_valid[i] = 0;
      m_ferr[i]  = 1'b0;
      if (v) begin
        if (!m_locked[i]) begin
          if (f) begin slot = 0; m_locked[i] = 1'b1; m_pos[i] = 1; end
        end else if (f) begin
          m_ferr[i] = (m_pos[i] != 0);
          slot = 0;
          m_pos[i] = 1;
        end else if (m_pos[i] == 0) begin
          m_ferr[i]   = 1'b1;
          m_locked[i] = 1'b0;
        end else begin
          slot = m_pos[i];
          m_pos[i] = (m_pos[i] + 1) % n;
        end
        if (slot >= 0 && !bad_eff) begin
          m_lane[i][slot] = d;
          m_valid[i] = 1 << slot;
        end
      end
    end
    m_perr = v && bad_eff;
  endtask

  task automatic compare_all();
    chk("out_l2",       64'(out2), exp_out(0));
    chk("out_valid_l2", 64'(ov2),  64'(m_valid[0]));
    chk("sel_l2",       64'(sel2), 64'(m_pos[0]));
    chk("locked_l2",    64'(lk2),  64'(m_locked[0]));
    chk("frame_err_l2", 64'(fe2),  64'(m_ferr[0]));
    chk("out_l3",       64'(out3), exp_out(1));
    chk("out_valid_l3", 64'(ov3),  64'(m_valid[1]));
    chk("sel_l3",       64'(sel3), 64'(m_pos[1]));
    chk("locked_l3",    64'(lk3),  64'(m_locked[1]));
    chk("frame_err_l3", 64'(fe3),  64'(m_ferr[1]));
`ifdef TDM_DEMUX_PARITY_EN
    chk("par_err_l2",   64'(pe2),  64'(m_perr));
    chk("par_err_l3",   64'(pe3),  64'(m_perr));
`endif
  endtask

  // One input word (or idle) per call; called at posedge+1, checks at next posedge+1.
  task automatic cycle(input bit v, input bit f, input logic [7:0] d, input bit bad);
    rst = 1'b0; in_valid = v; frame = f; din = d;
`ifdef TDM_DEMUX_PARITY_EN
    in_par = (^d) ^ bad;
`endif
    @(posedge clk);
    model_step(v, f, d, bad);
    #1;
    compare_all();
    n_txn++;
    $display("txn %0d rst=0 v=%0b f=%0b d=%h | l2 out=%h ov=%b sel=%0d lk=%0b fe=%0b | l3 out=%h ov=%b sel=%0d lk=%0b fe=%0b",
             n_txn, v, f, d, out2, ov2, sel2, lk2, fe2, out3, ov3, sel3, lk3, fe3);
  endtask

  // Asynchronous reset asserted between edges, held across one edge.
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; frame = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    n_txn++;
    $display("txn %0d rst=1 | l2 out=%h lk=%0b | l3 out=%h lk=%0b", n_txn, out2, lk2, out3, lk3);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; frame = 1'b0; din = '0;
`ifdef TDM_DEMUX_PARITY_EN
    in_par = 1'b0;
`endif
    model_reset();
    #12;
    compare_all();
    chk("lit_reset_out2",    64'(out2), 64'h0);
    chk("lit_reset_locked2", 64'(lk2),  64'h0);
    chk("lit_reset_sel3",    64'(sel3), 64'h0);

    // Basic frame: A5 to lane 0, 3C to lane 1.
    cycle(1, 1, 8'hA5, 0);
    chk("lit_a5_lane0",  64'(out2[7:0]), 64'hA5);
    chk("lit_a5_valid",  64'(ov2),       64'h1);
    chk("lit_a5_locked", 64'(lk2),       64'h1);
    chk("lit_model_a5",  64'(m_lane[0][0]), 64'hA5);
    cycle(1, 0, 8'h3C, 0);
    chk("lit_3c_lane1",  64'(out2[15:8]), 64'h3C);
    chk("lit_3c_valid",  64'(ov2),        64'h2);
    chk("lit_3c_ferr",   64'(fe2),        64'h0);
    chk("lit_3c_sel3",   64'(sel3),       64'h2);

    // HUNT discards unframed words.
    do_reset();
    cycle(1, 0, 8'h11, 0);
    chk("lit_hunt_valid_a", 64'(ov2), 64'h0);
    cycle(1, 0, 8'h22, 0);
    chk("lit_hunt_valid_b", 64'(ov2), 64'h0);
    chk("lit_hunt_locked",  64'(lk2), 64'h0);
    cycle(1, 1, 8'h33, 0);
    chk("lit_hunt_lane0",   64'(out2), 64'h0033);
    chk("lit_hunt_locked2", 64'(lk2),  64'h1);

    // Early frame on the 3-lane instance.
    do_reset();
    cycle(1, 1, 8'h01, 0);
    cycle(1, 0, 8'h02, 0);
    cycle(1, 1, 8'h04, 0);
    chk("lit_early_ferr3", 64'(fe3),  64'h1);
    chk("lit_early_out3",  64'(out3), 64'h000204);
    chk("lit_early_sel3",  64'(sel3), 64'h1);
    chk("lit_early_ov3",   64'(ov3),  64'h1);
    chk("lit_early_ferr2", 64'(fe2),  64'h0);
    chk("lit_model_early", 64'(m_ferr[1]), 64'h1);

    // Missing frame on the 2-lane instance.
    do_reset();
    cycle(1, 1, 8'h10, 0);
    cycle(1, 0, 8'h20, 0);
    cycle(1, 0, 8'h30, 0);
    chk("lit_miss_ferr2",   64'(fe2),  64'h1);
    chk("lit_miss_locked2", 64'(lk2),  64'h0);
    chk("lit_miss_out2",    64'(out2), 64'h2010);
    chk("lit_miss_ov2",     64'(ov2),  64'h0);
    chk("lit_miss_lane2_3", 64'(out3[23:16]), 64'h30);

    // Idle gaps (frame ignored while invalid), reset mid-frame, word in release cycle.
    do_reset();
    cycle(1, 1, 8'h01, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'hFF, 0);
    chk("lit_gap_sel2", 64'(sel2), 64'h1);
    do_reset();
    cycle(1, 0, 8'h02, 0);
    chk("lit_gap_out2", 64'(out2), 64'h0);
    chk("lit_gap_ov2",  64'(ov2),  64'h0);
    chk("lit_gap_lk2",  64'(lk2),  64'h0);

`ifdef TDM_DEMUX_PARITY_EN
    do_reset();
    cycle(1, 1, 8'h07, 1);
    chk("lit_par_err", 64'(pe2), 64'h1);
    chk("lit_par_ov2", 64'(ov2), 64'h0);
    cycle(1, 0, 8'h03, 0);
    chk("lit_par_lane1", 64'(out2[15:8]), 64'h03);
    chk("lit_par_ov2b",  64'(ov2),        64'h2);
`endif

    // Randomized traffic: mostly well-formed frames of period 2 then 3, with corruption.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      int per = (i < 750) ? 2 : 3;
      bit v = ($urandom % 4) != 0;
      bit f = v ? (((cnt % per) == 0) ^ (($urandom % 12) == 0)) : bit'($urandom % 2);
      bit bad = ($urandom % 16) == 0;
      if (($urandom % 300) == 0) begin
        do_reset();
        cnt = 0;
      end
      cycle(v, f, 8'($urandom), bad);
      if (v) cnt++;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
